// File: rtl/batch_sequencer_pkg.sv
// Shared types and constants for the random-bit capture/dump path:
// sequencer state encoding and the header bytes framed by the batch transmitter.
package batch_sequencer_pkg;

   localparam int unsigned BYTE_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CAPTURE = 3'd1,
      ST_ARM_RST = 3'd2,
      ST_ARM_GO  = 3'd3,
      ST_SEND    = 3'd4,
      ST_SETTLE  = 3'd5,
      ST_FINISH  = 3'd6
   } state_e;

   // Framing bytes the transmitter prepends to every dumped batch.
   localparam logic [7:0] HDR_SYNC0 = 8'hA5;
   localparam logic [7:0] HDR_SYNC1 = 8'h5A;
   localparam logic [7:0] HDR_BATCH = 8'hB7;

endpackage

// File: rtl/batch_sequencer_bit_packer.sv
// Packs a serial bit stream MSB first; byte_valid_o marks the cycle whose
// bit_i completes a byte, with the full byte presented on byte_o.
module batch_sequencer_bit_packer
   import batch_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear_i,
   input  logic       shift_en_i,
   input  logic       bit_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o
);

   logic [6:0] shift_q;
   logic [2:0] cnt_q;

   // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (shift_en_i) begin
         shift_q <= {shift_q[5:0], bit_i};
         cnt_q   <= cnt_q + 3'd1;
      end
   end

   assign byte_o       = {shift_q, bit_i};
   assign byte_valid_o = shift_en_i && (cnt_q == 3'(BYTE_BITS - 1));

endmodule

// File: rtl/batch_sequencer.sv
// Capture/dump sequencer: fills the batch memory from the bit packer, then
// hands the memory port to the UART transmitter and waits for it to finish.
module batch_sequencer
   import batch_sequencer_pkg::*;
#(
   parameter int unsigned BATCH_SIZE     = 1000,
   parameter int unsigned MEM_ADDR_WIDTH = $clog2(BATCH_SIZE),
   parameter int unsigned NUM_BATCHES    = 0,
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 2**28
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      run,
   input  logic                      bit_valid,
   input  logic                      bit_in,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]                mem_din,
   output logic                      mem_we,
   output logic                      mem_oe,
   input  logic [MEM_ADDR_WIDTH-1:0] tx_mem_addr,
   input  logic                      tx_mem_we,
   input  logic                      tx_mem_oe,
   output logic                      tx_start,
   output logic                      tx_rst,
   input  logic                      tx_done,
   output logic                      busy,
   output logic                      done,
   output logic                      timeout_err,
   output logic [15:0]               batch_cnt,
   output logic [15:0]               drop_cnt
);

   localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR    = MEM_ADDR_WIDTH'(BATCH_SIZE - 1);
   localparam logic [31:0]               TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]               SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
   localparam logic [15:0]               BATCH_LIMIT  = 16'(NUM_BATCHES);

   state_e                    state_q, state_d;
   logic [MEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [MEM_ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;
   logic [7:0]                cap_din_q, cap_din_d;
   logic                      cap_we_q, cap_we_d;
   logic [31:0]               wd_cnt_q, wd_cnt_d;
   logic [31:0]               settle_cnt_q, settle_cnt_d;
   logic [15:0]               batch_cnt_q, batch_cnt_d;
   logic [15:0]               drop_cnt_q, drop_cnt_d;
   logic                      timeout_err_q, timeout_err_d;
   logic                      kill_q, kill_d;
   logic                      capture_start;
   logic                      shift_en;
   logic [7:0]                packed_byte;
   logic                      byte_valid;

   // Dropping run in CAPTURE abandons the batch, so that cycle's bit is not taken.
   assign shift_en = (state_q == ST_CAPTURE) && run && bit_valid;

   batch_sequencer_bit_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (capture_start),
      .shift_en_i   (shift_en),
      .bit_i        (bit_in),
      .byte_o       (packed_byte),
      .byte_valid_o (byte_valid)
   );

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d       = state_q;
      wr_addr_d     = wr_addr_q;
      wd_cnt_d      = wd_cnt_q;
      settle_cnt_d  = settle_cnt_q;
      batch_cnt_d   = batch_cnt_q;
      timeout_err_d = timeout_err_q;
      kill_d        = 1'b0;
      capture_start = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d       = ST_CAPTURE;
               capture_start = 1'b1;
            end
         end
         ST_CAPTURE: begin
            if (!run) begin
               state_d = ST_IDLE;
            end else if (byte_valid) begin
               wr_addr_d = wr_addr_q + 1'b1;
               if (wr_addr_q == LAST_ADDR) state_d = ST_ARM_RST;
            end
         end
         ST_ARM_RST: state_d = ST_ARM_GO;
         ST_ARM_GO: begin
            wd_cnt_d = '0;
            state_d  = ST_SEND;
         end
         ST_SEND: begin
            // A done flag arriving on the expiry cycle still completes the batch.
            if (tx_done) begin
               batch_cnt_d  = batch_cnt_q + 16'd1;
               settle_cnt_d = '0;
               if ((NUM_BATCHES != 0) && (batch_cnt_d == BATCH_LIMIT)) state_d = ST_FINISH;
               else if (!run)                                         state_d = ST_IDLE;
               else                                                   state_d = ST_SETTLE;
            end else if (wd_cnt_q == TIMEOUT_LAST) begin
               timeout_err_d = 1'b1;
               kill_d        = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               wd_cnt_d = wd_cnt_q + 32'd1;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt_q == SETTLE_LAST) begin
               if (run) begin
                  state_d       = ST_CAPTURE;
                  capture_start = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               settle_cnt_d = settle_cnt_q + 32'd1;
            end
         end
         ST_FINISH: if (!run) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      if (capture_start) begin
         wr_addr_d     = '0;
         timeout_err_d = 1'b0;
      end
   end

   always_comb begin
      cap_we_d   = byte_valid;
      cap_addr_d = byte_valid ? wr_addr_q : cap_addr_q;
      cap_din_d  = byte_valid ? packed_byte : cap_din_q;
      drop_cnt_d = drop_cnt_q;
      if (bit_valid && (state_q != ST_CAPTURE) && (drop_cnt_q != 16'hFFFF))
         drop_cnt_d = drop_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         wr_addr_q     <= '0;
         cap_addr_q    <= '0;
         cap_din_q     <= '0;
         cap_we_q      <= 1'b0;
         wd_cnt_q      <= '0;
         settle_cnt_q  <= '0;
         batch_cnt_q   <= '0;
         drop_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
         kill_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_addr_q     <= wr_addr_d;
         cap_addr_q    <= cap_addr_d;
         cap_din_q     <= cap_din_d;
         cap_we_q      <= cap_we_d;
         wd_cnt_q      <= wd_cnt_d;
         settle_cnt_q  <= settle_cnt_d;
         batch_cnt_q   <= batch_cnt_d;
         drop_cnt_q    <= drop_cnt_d;
         timeout_err_q <= timeout_err_d;
         kill_q        <= kill_d;
      end
   end

   // Only one master owns the memory port at a time; the capture write lands in ARM_RST too.
   always_comb begin
      mem_addr = '0;
      mem_din  = '0;
      mem_we   = 1'b0;
      mem_oe   = 1'b0;
      unique case (state_q)
         ST_CAPTURE, ST_ARM_RST: begin
            mem_addr = cap_addr_q;
            mem_din  = cap_din_q;
            mem_we   = cap_we_q;
         end
         ST_SEND: begin
            mem_addr = tx_mem_addr;
            mem_we   = tx_mem_we;
            mem_oe   = tx_mem_oe;
         end
         default: ;
      endcase
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_FINISH);
   assign tx_start    = (state_q == ST_ARM_GO);
   assign tx_rst      = rst || (state_q == ST_ARM_RST) || kill_q;
   assign timeout_err = timeout_err_q;
   assign batch_cnt   = batch_cnt_q;
   assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_batch_sequencer.sv
// Self-checking bench: scoreboarded capture writes, a behavioural transmitter,
// batch counting, run abort, watchdog, drop saturation and mid-run reset.
module tb_batch_sequencer;

   localparam int BATCH = 4;

   typedef struct packed {
      logic [1:0] addr;
      logic [7:0] data;
   } wr_t;

   logic       clk;
   logic       rst, run, bit_valid, bit_in;
   logic [1:0] mem_addr, tx_mem_addr;
   logic [7:0] mem_din;
   logic       mem_we, mem_oe, tx_mem_we, tx_mem_oe;
   logic       tx_start, tx_rst, tx_done;
   logic       busy, done, timeout_err;
   logic [15:0] batch_cnt, drop_cnt;

   wr_t sb[$];
   int  n_checks = 0;
   int  n_errors = 0;
   bit  hang = 1'b0;
   int  tcnt;
   bit  active;

   batch_sequencer #(
      .BATCH_SIZE     (BATCH),
      .NUM_BATCHES    (2),
      .SETTLE_CYCLES  (3),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .bit_valid   (bit_valid),
      .bit_in      (bit_in),
      .mem_addr    (mem_addr),
      .mem_din     (mem_din),
      .mem_we      (mem_we),
      .mem_oe      (mem_oe),
      .tx_mem_addr (tx_mem_addr),
      .tx_mem_we   (tx_mem_we),
      .tx_mem_oe   (tx_mem_oe),
      .tx_start    (tx_start),
      .tx_rst      (tx_rst),
      .tx_done     (tx_done),
      .busy        (busy),
      .done        (done),
      .timeout_err (timeout_err),
      .batch_cnt   (batch_cnt),
      .drop_cnt    (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives nbits of b MSB first; the 8th bit queues the expected write.
   task automatic send_bits(input logic [7:0] b, input int nbits, input int gap,
                            input logic [1:0] addr);
      for (int i = 0; i < nbits; i++) begin
         bit_valid = 1'b1;
         bit_in    = b[7-i];
         if (i == 7) sb.push_back('{addr: addr, data: b});
         tick();
      end
      bit_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_tx_start"}, tx_start, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_mem_oe"}, mem_oe, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_din"}, mem_din, 0);
      check({tag, "_timeout_err"}, timeout_err, 0);
      check({tag, "_batch_cnt"}, batch_cnt, 0);
      check({tag, "_drop_cnt"}, drop_cnt, 0);
      check({tag, "_tx_rst"}, tx_rst, 1);
   endtask

   // Transmitter model: re-armed by tx_rst, sweeps reads after tx_start, raises a sticky done.
   initial begin
      tx_done = 1'b0; tx_mem_oe = 1'b0; tx_mem_we = 1'b0; tx_mem_addr = '0;
      active = 1'b0; tcnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (tx_rst) begin
            active = 1'b0; tx_done = 1'b0; tx_mem_oe = 1'b0; tx_mem_addr = '0;
         end else if (tx_start) begin
            active = 1'b1; tcnt = 0;
         end else if (active) begin
            tcnt++;
            if (tcnt >= 50 && !hang) begin
               tx_done = 1'b1; active = 1'b0; tx_mem_oe = 1'b0;
            end else begin
               tx_mem_oe   = 1'b1;
               tx_mem_addr = tcnt[1:0];
            end
         end
      end
   end

   // Output monitor: capture writes against the scoreboard, SEND passthrough against the model.
   always @(negedge clk) begin
      wr_t exp_wr;
      if (mem_we) begin
         if (sb.size() == 0) begin
            check("unexpected_write", 32'(mem_we), 0);
         end else begin
            exp_wr = sb.pop_front();
            check("wr_addr", mem_addr, exp_wr.addr);
            check("wr_data", mem_din, exp_wr.data);
         end
      end
      if (busy && tx_mem_oe) begin
         check("pt_oe", mem_oe, 1);
         check("pt_addr", mem_addr, tx_mem_addr);
      end
   end

   initial begin
      int k;
      rst = 1'b1; run = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
      repeat (3) tick();
      check_idle_outputs("reset");
      rst = 1'b0;
      tick();
      check("rel_tx_rst", tx_rst, 0);

      // Five drops in IDLE.
      bit_valid = 1'b1;
      repeat (5) tick();
      bit_valid = 1'b0;
      check("drop_idle", drop_cnt, 5);

      // Batch 1.
      run = 1'b1;
      tick();
      send_bits(8'hA5, 8, 2, 2'd0);
      send_bits(8'h3C, 8, 0, 2'd1);
      send_bits(8'hFF, 8, 1, 2'd2);
      send_bits(8'h00, 8, 0, 2'd3);
      check("arm_tx_rst", tx_rst, 1);
      check("arm_tx_start", tx_start, 0);
      check("arm_last_we", mem_we, 1);
      tick();
      check("go_tx_start", tx_start, 1);
      check("go_tx_rst", tx_rst, 0);
      tick();
      check("send_tx_start", tx_start, 0);
      check("send_busy", busy, 1);
      check("b1_sb_empty", sb.size(), 0);
      for (k = 0; k < 200 && batch_cnt != 16'd1; k++) tick();
      check("b1_batch_cnt", batch_cnt, 1);
      check("b1_not_done", done, 0);

      // Three drops in SETTLE, then batch 2 starts on its own.
      bit_valid = 1'b1;
      repeat (3) tick();
      bit_valid = 1'b0;
      check("drop_settle", drop_cnt, 8);
      send_bits(8'h12, 8, 0, 2'd0);
      send_bits(8'h34, 8, 3, 2'd1);
      send_bits(8'h56, 8, 0, 2'd2);
      send_bits(8'h78, 8, 0, 2'd3);
      for (k = 0; k < 200 && !done; k++) tick();
      check("b2_done", done, 1);
      check("b2_batch_cnt", batch_cnt, 2);
      check("b2_busy", busy, 1);
      check("b2_sb_empty", sb.size(), 0);
      run = 1'b0;
      tick();
      check("fin_done_clr", done, 0);
      check("fin_busy", busy, 0);

      // Abort after 13 bits: one write only.
      run = 1'b1;
      tick();
      send_bits(8'hC3, 8, 0, 2'd0);
      send_bits(8'hE0, 5, 0, 2'd0);
      run = 1'b0;
      tick();
      check("abort_busy", busy, 0);
      check("abort_sb_empty", sb.size(), 0);

      // Restart at address 0, transmitter hangs, watchdog fires.
      hang = 1'b1;
      run  = 1'b1;
      tick();
      send_bits(8'h5A, 8, 0, 2'd0);
      send_bits(8'h01, 8, 0, 2'd1);
      send_bits(8'h80, 8, 0, 2'd2);
      send_bits(8'h7E, 8, 0, 2'd3);
      tick();
      check("wd_tx_start", tx_start, 1);
      repeat (100) tick();
      check("wd_no_err_yet", timeout_err, 0);
      check("wd_busy_yet", busy, 1);
      tick();
      check("wd_err", timeout_err, 1);
      check("wd_tx_rst", tx_rst, 1);
      check("wd_idle", busy, 0);
      run = 1'b0;
      tick();
      check("wd_err_sticky", timeout_err, 1);
      check("wd_tx_rst_clr", tx_rst, 0);
      check("wd_batch_cnt", batch_cnt, 2);
      check("wd_sb_empty", sb.size(), 0);
      hang = 1'b0;

      // Drop counter saturation.
      bit_valid = 1'b1;
      repeat (70000) tick();
      bit_valid = 1'b0;
      check("drop_sat", drop_cnt, 16'hFFFF);

      // Reset mid-CAPTURE.
      run = 1'b1;
      tick();
      send_bits(8'hFF, 3, 0, 2'd0);
      rst = 1'b1;
      tick();
      check_idle_outputs("rst_cap");
      rst = 1'b0;
      tick();

      // Reset mid-SEND.
      send_bits(8'h11, 8, 0, 2'd0);
      send_bits(8'h22, 8, 0, 2'd1);
      send_bits(8'h33, 8, 0, 2'd2);
      send_bits(8'h44, 8, 0, 2'd3);
      tick();
      repeat (10) tick();
      check("rst_send_busy_pre", busy, 1);
      rst = 1'b1;
      tick();
      check_idle_outputs("rst_send");
      rst = 1'b0;
      run = 1'b0;
      tick();
      check("rst_send_tx_rst_clr", tx_rst, 0);
      check("final_sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/batch_sequencer.md
Name: batch_sequencer

Overview:
- Top-level sequencer for the random-bit capture/dump path.
- Packs a serial bit source into bytes and writes BATCH_SIZE bytes into the single-port batch memory.
- Then arms and starts the batch UART transmitter, waits for its done flag, and repeats for NUM_BATCHES batches (or continuously).
- Owns the memory port: it muxes between its own capture writer and the transmitter's read port, so the two never drive the memory at once.

Parameters:
- BATCH_SIZE, 1000: bytes per batch.
- MEM_ADDR_WIDTH, $clog2(BATCH_SIZE): memory address width.
- NUM_BATCHES, 0: batches per run; 0 = continuous.
- SETTLE_CYCLES, 16: idle gap between tx_done and the next capture (≥1).
- TIMEOUT_CYCLES, 2**28: SEND watchdog limit (32-bit counter).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- run  in  1  level enable for the sequence
- bit_valid  in  1  bit_in is valid this cycle
- bit_in  in  1  raw random bit
- mem_addr  out  MEM_ADDR_WIDTH  memory address
- mem_din  out  8  memory write data
- mem_we  out  1  memory write enable
- mem_oe  out  1  memory output enable
- tx_mem_addr  in  MEM_ADDR_WIDTH  transmitter read address
- tx_mem_we  in  1  transmitter write enable
- tx_mem_oe  in  1  transmitter output enable
- tx_start  out  1  one-cycle start pulse to the transmitter
- tx_rst  out  1  transmitter re-arm reset
- tx_done  in  1  transmitter done (sticky until tx_rst)
- busy  out  1  state != IDLE
- done  out  1  all NUM_BATCHES batches sent
- timeout_err  out  1  sticky watchdog error
- batch_cnt  out  16  batches completed (wraps)
- drop_cnt  out  16  valid bits discarded outside CAPTURE (saturating)

Behaviour:
- Reset values:
  - Outputs 0, except tx_rst.
  - tx_rst = rst OR arm pulse (combinational), so the transmitter is held in reset with this block.
  - Internal: state = IDLE, wr_addr = 0, bit count = 0, counters = 0.
- States: IDLE, CAPTURE, ARM_RST, ARM_GO, SEND, SETTLE, FINISH.
- IDLE:
  - run = 1 → CAPTURE.
  - On entry to CAPTURE: clear wr_addr, bit count, timeout_err.
- CAPTURE:
  - Each cycle with bit_valid = 1 shifts bit_in in, MSB first.
  - The edge sampling the 8th bit registers:
    - mem_din = {shift[6:0], bit_in}
    - mem_addr = wr_addr
    - mem_we = 1 for exactly one cycle
    - wr_addr++
  - When the written address is BATCH_SIZE-1 → ARM_RST on the same edge. The final write pulse is visible in the first ARM_RST cycle.
  - run = 0 → IDLE. Partial byte discarded; completed bytes stay in memory but are never sent.
- ARM_RST: tx_rst = 1 for one cycle → ARM_GO.
- ARM_GO: tx_start = 1 for one cycle; watchdog cleared → SEND.
- SEND:
  - Memory port is a combinational passthrough of tx_mem_*.
  - On tx_done = 1: batch_cnt++. Then:
    - NUM_BATCHES != 0 and the new count equals NUM_BATCHES → FINISH.
    - run = 0 → IDLE.
    - Otherwise → SETTLE.
  - run = 0 during SEND does not abort; the batch always completes.
  - Watchdog reaches TIMEOUT_CYCLES-1 without tx_done → timeout_err = 1, tx_rst pulsed one cycle, → IDLE.
- SETTLE:
  - Count SETTLE_CYCLES.
  - At expiry: run = 1 → CAPTURE (wr_addr = 0), else IDLE.
- FINISH: done = 1; held until run = 0, then → IDLE (done = 0).
- Memory mux:
  - CAPTURE and ARM_RST: capture registers drive the port, with mem_oe = 0.
  - SEND: passthrough of tx_mem_*.
  - All other states: mem_we = mem_oe = 0, mem_addr = 0.
- drop_cnt: increments on every bit_valid outside CAPTURE; saturates at 16'hFFFF; cleared only by rst.
- Simultaneous events:
  - tx_done and watchdog expiry in the same cycle → tx_done wins; no error.
  - bit_valid on the edge leaving CAPTURE for the last byte → that bit counts as the 8th bit, not a drop.
- rst mid-operation: immediate return to IDLE with all reset values. The memory contents are not cleared.

Decomposition:
- Shared package: state encoding localparams, and the header byte constants used by the transmitter.
- One sub-module is natural: bit_packer (8-bit MSB-first shift, bit counter, byte_valid pulse).
- Sequencing FSM, memory mux and counters stay in batch_sequencer.

Test Plan (bench BATCH_SIZE = 4, SETTLE_CYCLES = 3, behavioural memory + transmitter model):
- run = 1, 32 bits (pattern 0xA5, 0x3C, 0xFF, 0x00) with gaps → four mem_we pulses at addr 0..3 with those data; then one tx_rst cycle, then one tx_start cycle.
- NUM_BATCHES = 2, model raises tx_done 50 cycles after start → batch_cnt = 2, done = 1; run = 0 → IDLE, done = 0.
- run dropped after 13 bits → exactly 1 write (addr 0), state IDLE; next run restarts at addr 0.
- Model never raises tx_done, TIMEOUT_CYCLES = 100 → timeout_err = 1 on cycle 100 of SEND, tx_rst pulse, IDLE.
- bit_valid = 1 for 5 cycles in IDLE and 3 cycles in SETTLE → drop_cnt = 8; with 70000 drops drop_cnt holds 16'hFFFF.
- rst asserted mid-CAPTURE and mid-SEND → next cycle: all outputs 0, tx_rst = 1 while rst is high, busy = 0.
